// File: rtl/fifo_sc_prog.sv
// fifo_sc_prog: single-clock FIFO, programmable almost flags, registered or FWFT read; optional FIFO_ERR_FLAGS_EN sticky error flags
module fifo_sc_prog #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = RAM_DEPTH - 8,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);
  if (RAM_DEPTH != (1 << ADDR_WIDTH) || AF_THRESH < 0 || AF_THRESH > RAM_DEPTH ||
      AE_THRESH < 0 || AE_THRESH > RAM_DEPTH) begin : g_bad_param
    $error("fifo_sc_prog: illegal depth or threshold parameters");
  end
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, head_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  push_ok, pop_ok, rd_valid;
  assign empty        = fifo_count == '0;
  assign full         = fifo_count == DEPTH_C;
  assign almost_full  = fifo_count >= AF_C;
  assign almost_empty = fifo_count <= AE_C;
  assign out_valid    = (FWFT != 0) ? !empty : rd_valid;
  // accept rules, and the slot that will be head after this edge
  always_comb begin
    push_ok    = push && (!full || pop);
    pop_ok     = pop && !empty;
    head_ptr   = rd_ptr + ADDR_WIDTH'(pop_ok);
    count_next = fifo_count + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
  end
  // pointers and occupancy; pointers wrap naturally at their width
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + ADDR_WIDTH'(push_ok);
      rd_ptr     <= head_ptr;
      fifo_count <= count_next;
    end
  end
  // storage, never cleared by reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end
  // output word: popped word (registered mode) or next head (FWFT), read-first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (FWFT != 0) begin
        if (count_next != '0) data_out <= (push_ok && head_ptr == wr_ptr) ? data_in : mem[head_ptr];
      end else if (pop_ok) begin
        data_out <= mem[rd_ptr];
      end
    end
  end
`ifdef FIFO_ERR_FLAGS_EN
  // sticky misuse flags, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (push && full && !pop);
      underflow <= underflow | (pop && empty);
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_sc_prog.sv
// tb_fifo_sc_prog: table vectors, directed corners and queue-model random test for both read modes
module tb_fifo_sc_prog;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, push = 1'b0, pop = 1'b0;
  logic [63:0] data_in = '0;
  logic [63:0] d0, d1;
  logic v0, e0, f0, af0, ae0, ov0, un0, v1, e1, f1, af1, ae1, ov1, un1;
  logic [4:0] c0, c1;
  int checks = 0, errors = 0;
  logic [63:0] q[$];
  logic [63:0] m_d0, m_d1;
  logic m_v0, m_ov, m_un;

  fifo_sc_prog #(.FWFT(0)) dut0 (.clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data_out(d0), .out_valid(v0), .empty(e0), .full(f0), .almost_full(af0), .almost_empty(ae0),
    .fifo_count(c0), .overflow(ov0), .underflow(un0));
  fifo_sc_prog #(.FWFT(1)) dut1 (.clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data_out(d1), .out_valid(v1), .empty(e1), .full(f1), .almost_full(af1), .almost_empty(ae1),
    .fifo_count(c1), .overflow(ov1), .underflow(un1));

  always #5 clk = ~clk;

  typedef struct {
    logic p, q;
    logic [63:0] d;
    int cnt;
    logic [63:0] d0;
    logic v0;
    logic [63:0] d1;
    logic v1;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic r, input logic [63:0] d);
    push = p; pop = r; data_in = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; push = 1'b0; pop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete(); m_d0 = '0; m_d1 = '0; m_v0 = 1'b0; m_ov = 1'b0; m_un = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input int n);
    chk({tag, " count0"}, 64'(c0), 64'(n));
    chk({tag, " count1"}, 64'(c1), 64'(n));
    chk({tag, " empty"}, 64'({e0, e1}), n == 0 ? 64'd3 : 64'd0);
    chk({tag, " full"}, 64'({f0, f1}), n == 16 ? 64'd3 : 64'd0);
    chk({tag, " afull"}, 64'({af0, af1}), n >= 8 ? 64'd3 : 64'd0);
    chk({tag, " aempty"}, 64'({ae0, ae1}), n <= 2 ? 64'd3 : 64'd0);
  endtask

  // queue reference: pop from the front before appending, accept rules from occupancy
  task automatic model_step(input logic p, input logic r, input logic [63:0] d);
    bit pa, wa;
    pa = r && q.size() > 0;
    wa = p && (q.size() < 16 || r);
    if (p && q.size() == 16 && !r) m_ov = 1'b1;
    if (r && q.size() == 0) m_un = 1'b1;
    m_v0 = pa;
    if (pa) m_d0 = q.pop_front();
    if (wa) q.push_back(d);
    if (q.size() > 0) m_d1 = q[0];
  endtask

  task automatic chk_model();
    chk_flags("rnd", q.size());
    chk("rnd dout0", d0, m_d0);
    chk("rnd valid0", 64'(v0), 64'(m_v0));
    chk("rnd dout1", d1, m_d1);
    chk("rnd valid1", 64'(v1), 64'(q.size() > 0));
    chk("rnd ovf", 64'({ov0, ov1}), (ERR && m_ov) ? 64'd3 : 64'd0);
    chk("rnd unf", 64'({un0, un1}), (ERR && m_un) ? 64'd3 : 64'd0);
  endtask

  initial begin
    for (int i = 1; i <= 16; i++) tv.push_back('{1'b1, 1'b0, 64'(i), i, 64'd0, 1'b0, 64'd1, 1'b1});
    tv.push_back('{1'b1, 1'b1, 64'h99, 16, 64'd1, 1'b1, 64'd2, 1'b1});
    for (int k = 1; k <= 15; k++)
      tv.push_back('{1'b0, 1'b1, 64'd0, 16 - k, 64'(k + 1), 1'b1, k < 15 ? 64'(k + 2) : 64'h99, 1'b1});
    tv.push_back('{1'b0, 1'b1, 64'd0, 0, 64'h99, 1'b1, 64'h99, 1'b0});
    tv.push_back('{1'b0, 1'b0, 64'd0, 0, 64'h99, 1'b0, 64'h99, 1'b0});
    tv.push_back('{1'b0, 1'b1, 64'd0, 0, 64'h99, 1'b0, 64'h99, 1'b0});
    do_reset();
    chk_flags("reset", 0);
    chk("reset dout", {d0 | d1}, 64'd0);
    chk("reset valid", 64'({v0, v1}), 64'd0);
    chk("reset errflags", 64'({ov0, un0, ov1, un1}), 64'd0);
    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].p, tv[i].q, tv[i].d);
      chk_flags($sformatf("vec%0d", i), tv[i].cnt);
      chk($sformatf("vec%0d dout0", i), d0, tv[i].d0);
      chk($sformatf("vec%0d valid0", i), 64'(v0), 64'(tv[i].v0));
      chk($sformatf("vec%0d dout1", i), d1, tv[i].d1);
      chk($sformatf("vec%0d valid1", i), 64'(v1), 64'(tv[i].v1));
    end
    // registered read: valid for exactly the cycle after each pop
    do_reset();
    cyc(1, 0, 64'hA);
    cyc(1, 0, 64'hB);
    cyc(0, 1, 0);
    chk("reg pop1 dout", d0, 64'hA);
    chk("reg pop1 valid", 64'(v0), 64'd1);
    cyc(0, 0, 0);
    chk("reg idle valid", 64'(v0), 64'd0);
    chk("reg idle hold", d0, 64'hA);
    cyc(0, 1, 0);
    chk("reg pop2 dout", d0, 64'hB);
    chk("reg pop2 empty", 64'(e0), 64'd1);
    // fall-through: head visible one edge after push, held after last pop
    do_reset();
    cyc(1, 0, 64'h55);
    chk("fwft head", d1, 64'h55);
    chk("fwft valid", 64'(v1), 64'd1);
    cyc(0, 1, 0);
    chk("fwft drain", 64'({e1, v1}), 64'b10);
    chk("fwft hold", d1, 64'h55);
    // misuse: pop on empty, push on full without pop
    do_reset();
    cyc(0, 1, 0);
    chk("unf set", 64'({un0, un1}), ERR ? 64'd3 : 64'd0);
    for (int i = 0; i < 16; i++) cyc(1, 0, 64'(i + 32));
    cyc(1, 0, 64'hDEAD);
    chk("ovf set", 64'({ov0, ov1}), ERR ? 64'd3 : 64'd0);
    chk_flags("ovf", 16);
    cyc(0, 1, 0);
    chk("ovf keep data", d0, 64'd32);
    chk("sticky", 64'({ov0, un0}), ERR ? 64'd3 : 64'd0);
    // async reset mid-stream takes effect before the next edge
    do_reset();
    chk("rst clears flags", 64'({ov0, un0, ov1, un1}), 64'd0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 64'(i + 100));
    chk("pre-rst count", 64'(c0), 64'd5);
    push = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_flags("async rst", 0);
    chk("async rst dout", {d0 | d1}, 64'd0);
    chk("async rst valid", 64'({v0, v1}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    q.delete(); m_d0 = '0; m_d1 = '0; m_v0 = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 64'(i + 200));
    chk("post-rst head", d1, 64'd200);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0);
      chk("post-rst order", d0, 64'(i + 200));
    end
    // random traffic against the queue model, alternating fill/drain bias
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic p, r;
      logic [63:0] d;
      p = ($urandom_range(99) < (((i / 60) % 2) ? 25 : 75));
      r = ($urandom_range(99) < (((i / 60) % 2) ? 75 : 25));
      d = {$urandom, $urandom};
      cyc(p, r, d);
      model_step(p, r, d);
      chk_model();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
